// File: rtl/decode_pkg.sv
// Shared opcodes, format codes and the decoded-entry layout for the RV32I/RV64I decode stage.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd7
  } fmt_e;

  // imm and pc are held at the widest XLEN; the stage slices to its own width
  typedef struct packed {
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    fmt_e                fmt;
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] pc;
    logic                illegal;
  } entry_t;

  function automatic fmt_e fmt_of(input logic [6:0] op, input logic rv64);
    fmt_e f;
    case (op)
      OP_REG:                              f = FMT_R;
      OP_REG32:                            f = rv64 ? FMT_R : FMT_X;
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: f = FMT_I;
      OP_IMM32:                            f = rv64 ? FMT_I : FMT_X;
      OP_STORE:                            f = FMT_S;
      OP_BRANCH:                           f = FMT_B;
      OP_LUI, OP_AUIPC:                    f = FMT_U;
      OP_JAL:                              f = FMT_J;
      default:                             f = FMT_X;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: sign-extends the format's immediate field to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = XLEN'($signed(instr[31:20]));
      FMT_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

  // opcode bits never contribute to an immediate
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

endmodule

// File: rtl/decode_stage.sv
// Pipelined instruction decode with a DEPTH-entry decoded buffer and single-cycle flush.
// Define DECODE_ILLEGAL_CHK_EN to compute and store a per-entry illegal-encoding flag.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam int         CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic       RV64    = (XLEN == 64);

  fmt_e            fmt_in;
  logic [XLEN-1:0] imm_in;
  entry_t          entry_d;

  assign fmt_in = fmt_of(in_instr[6:0], RV64);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt_in),
    .imm   (imm_in)
  );

  always_comb begin
    entry_d         = '0;
    entry_d.opcode  = in_instr[6:0];
    entry_d.func3   = in_instr[14:12];
    entry_d.func7   = in_instr[31:25];
    entry_d.rs1     = in_instr[19:15];
    entry_d.rs2     = in_instr[24:20];
    entry_d.rd      = in_instr[11:7];
    entry_d.fmt     = fmt_in;
    entry_d.imm     = XLEN_MAX'($signed(imm_in));
    entry_d.pc      = XLEN_MAX'(in_pc);
`ifdef DECODE_ILLEGAL_CHK_EN
    entry_d.illegal = (fmt_in == FMT_X) || (in_instr[1:0] != 2'b11) ||
                      ((fmt_in == FMT_R) && !(in_instr[31:25] inside {7'b0000000, 7'b0100000, 7'b0000001}));
`endif
  end

  // ---- buffer control: flush overrides both push and pop ----
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign in_ready  = rst_n && (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ---- entry storage (data only, no reset) ----
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  // Outputs are forced to zero whenever nothing is buffered, which also covers reset
  entry_t head;
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_opcode = head.opcode;
  assign out_func3  = head.func3;
  assign out_func7  = head.func7;
  assign out_rs1    = head.rs1;
  assign out_rs2    = head.rs2;
  assign out_rd     = head.rd;
  assign out_fmt    = head.fmt;
  assign out_imm    = head.imm[XLEN-1:0];
  assign out_pc     = head.pc[XLEN-1:0];
`ifdef DECODE_ILLEGAL_CHK_EN
  assign out_illegal = head.illegal;
`else
  assign out_illegal = 1'b0;
`endif

  logic unused_head;
  assign unused_head = ^{head.imm, head.pc, head.illegal};

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, DEPTH=2): decode fields, backpressure, flush, reset.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [2:0]  out_fmt;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        out_illegal;

  int total  = 0;
  int passed = 0;
  int failed = 0;

`ifdef DECODE_ILLEGAL_CHK_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  decode_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_func3   (out_func3),
    .out_func7   (out_func7),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_fmt     (out_fmt),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic expect_entry(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] rd, input logic [2:0] fmt, input logic [31:0] imm,
                              input logic [31:0] pc, input logic ill);
    chk({tag, ".valid"},  out_valid,   1);
    chk({tag, ".opcode"}, out_opcode,  op);
    chk({tag, ".func3"},  out_func3,   f3);
    chk({tag, ".func7"},  out_func7,   f7);
    chk({tag, ".rs1"},    out_rs1,     r1);
    chk({tag, ".rs2"},    out_rs2,     r2);
    chk({tag, ".rd"},     out_rd,      rd);
    chk({tag, ".fmt"},    out_fmt,     fmt);
    chk({tag, ".imm"},    out_imm,     imm);
    chk({tag, ".pc"},     out_pc,      pc);
    chk({tag, ".ill"},    out_illegal, ill);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

    // reset state
    #2;
    chk("rst.in_ready",  in_ready,   0);
    chk("rst.out_valid", out_valid,  0);
    chk("rst.opcode",    out_opcode, 0);
    chk("rst.imm",       out_imm,    0);
    chk("rst.pc",        out_pc,     0);
    chk("rst.fmt",       out_fmt,    0);
    #10 rst_n = 1'b1;
    #1;
    chk("post_rst.in_ready",  in_ready,  1);
    chk("post_rst.out_valid", out_valid, 0);

    // streaming decode, one per cycle with out_ready high
    out_ready = 1'b1;
    drive(32'h0010A103, 32'h100); tick();
    expect_entry("lw",   7'h03, 3'd2, 7'h00, 5'd1, 5'd1,  5'd2,    3'd1, 32'h1,        32'h100, 1'b0);
    drive(32'hFE000EE3, 32'h104); tick();
    expect_entry("beq",  7'h63, 3'd0, 7'h7F, 5'd0, 5'd0,  5'h1D,   3'd3, 32'hFFFFFFFC, 32'h104, 1'b0);
    drive(32'hFE112C23, 32'h108); tick();
    expect_entry("sw",   7'h23, 3'd2, 7'h7F, 5'd2, 5'd1,  5'h18,   3'd2, 32'hFFFFFFF8, 32'h108, 1'b0);
    drive(32'h008000EF, 32'h10C); tick();
    expect_entry("jal",  7'h6F, 3'd0, 7'h00, 5'd0, 5'd8,  5'd1,    3'd5, 32'h8,        32'h10C, 1'b0);
    drive(32'h002081B3, 32'h110); tick();
    expect_entry("add",  7'h33, 3'd0, 7'h00, 5'd1, 5'd2,  5'd3,    3'd0, 32'h0,        32'h110, 1'b0);
    drive(32'h123452B7, 32'h114); tick();
    expect_entry("lui",  7'h37, 3'd5, 7'h09, 5'd8, 5'd3,  5'd5,    3'd4, 32'h12345000, 32'h114, 1'b0);
    drive(32'hFFF00093, 32'h118); tick();
    expect_entry("addi", 7'h13, 3'd0, 7'h7F, 5'd0, 5'd31, 5'd1,    3'd1, 32'hFFFFFFFF, 32'h118, 1'b0);
    drive(32'h00000000, 32'h11C); tick();
    expect_entry("zero", 7'h00, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,    3'd7, 32'h0,        32'h11C, EXP_ILL);
    drive(32'h202081B3, 32'h120); tick();
    expect_entry("badR", 7'h33, 3'd0, 7'h10, 5'd1, 5'd2,  5'd3,    3'd0, 32'h0,        32'h120, EXP_ILL);
    in_valid = 1'b0; tick();
    chk("drain.out_valid", out_valid, 0);

    // backpressure: two accepts fill the buffer, third waits for a pop
    out_ready = 1'b0;
    drive(32'h0010A103, 32'h0); tick();
    chk("bp1.in_ready", in_ready, 1);
    drive(32'h002081B3, 32'h4); tick();
    chk("bp2.in_ready", in_ready, 0);
    chk("bp2.out_pc",   out_pc,   32'h0);
    drive(32'h008000EF, 32'h8); tick();
    chk("bp3.in_ready", in_ready, 0);
    chk("bp3.out_pc",   out_pc,   32'h0);
    chk("bp3.opcode",   out_opcode, 7'h03);
    out_ready = 1'b1; tick();
    chk("bp4.out_pc",   out_pc,   32'h4);
    chk("bp4.in_ready", in_ready, 1);
    tick();
    chk("bp5.out_pc",   out_pc,   32'h8);
    chk("bp5.opcode",   out_opcode, 7'h6F);
    in_valid = 1'b0; tick();
    chk("bp6.out_valid", out_valid, 0);

    // flush with a full buffer and a word offered
    out_ready = 1'b0;
    drive(32'h0010A103, 32'h20); tick();
    drive(32'h002081B3, 32'h24); tick();
    chk("fl0.out_valid", out_valid, 1);
    drive(32'h008000EF, 32'h28); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1.out_valid", out_valid, 0);
    chk("fl1.in_ready",  in_ready,  1);
    out_ready = 1'b1; tick();
    chk("fl2.out_valid", out_valid, 0);

    // flush while the offered word would otherwise be accepted
    out_ready = 1'b0;
    drive(32'h0010A103, 32'h30); tick();
    drive(32'hFE000EE3, 32'h34); flush = 1'b1; tick();
    flush = 1'b0;
    chk("fl3.out_valid", out_valid, 0);
    chk("fl3.in_ready",  in_ready,  1);
    drive(32'h123452B7, 32'h40); tick();
    in_valid = 1'b0;
    chk("fl4.out_pc",   out_pc,     32'h40);
    chk("fl4.opcode",   out_opcode, 7'h37);

    // asynchronous reset with one entry buffered
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    drive(32'hFE112C23, 32'h60); tick();
    in_valid = 1'b0;
    chk("ar0.out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar1.out_valid", out_valid,  0);
    chk("ar1.in_ready",  in_ready,   0);
    chk("ar1.pc",        out_pc,     0);
    chk("ar1.imm",       out_imm,    0);
    chk("ar1.opcode",    out_opcode, 0);
    chk("ar1.rs1",       out_rs1,    0);
    #1 rst_n = 1'b1;
    #1;
    chk("ar2.in_ready",  in_ready,  1);
    chk("ar2.out_valid", out_valid, 0);
    tick();
    chk("ar3.out_valid", out_valid, 0);
    out_ready = 1'b1;
    drive(32'h0010A103, 32'h200); tick();
    in_valid = 1'b0;
    chk("ar4.out_pc",    out_pc,    32'h200);
    chk("ar4.out_valid", out_valid, 1);
    tick();
    chk("ar5.out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined RV32I/RV64I instruction-decode stage with valid/ready handshakes on both sides and an internal decoded-instruction buffer. It takes raw instruction words and their PC from fetch and extracts opcode, func3, full func7, register indices, instruction format and a sign-extended XLEN immediate for every base format. Results are queued to execute, and a single-cycle flush supports branch redirection.

## Interface
- XLEN, 32: datapath width, 32 or 64. Sets the immediate and PC width; 64 also enables the OP-IMM-32 and OP-32 opcodes.
- DEPTH, 2: decoded-entry buffer depth, power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous; discards all buffered entries and the current-cycle input.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute accepts the head entry.
- out_opcode  out  7  instr[6:0].
- out_func3  out  3  instr[14:12].
- out_func7  out  7  instr[31:25].
- out_rs1 / out_rs2 / out_rd  out  5 each  instr[19:15] / [24:20] / [11:7], raw and unconditioned by format.
- out_fmt  out  3  decoded format code.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  PC carried with the entry.
- out_illegal  out  1  illegal-encoding flag.

## Operation
- Accept occurs when in_valid && in_ready. The word is decoded combinationally and the result is written at the buffer tail on the same edge.
- in_ready = (count < DEPTH). It does not depend on out_ready, so there is no pass-through when the buffer is full.
- Pop occurs when out_valid && out_ready. out_valid = (count != 0). Outputs show the head entry.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Format by opcode:
  - R: 0110011, plus 0111011 when XLEN=64.
  - I: 0000011, 0010011, 1100111, 1110011, plus 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else: X.
- Format codes: R=0, I=1, S=2, B=3, U=4, J=5, X=7.
- Immediate by format, each sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and X: 0.
- Flush has priority over push and pop. It sets count to 0 and resets the pointers, and any input accepted in the same cycle is dropped. in_ready is 1 on the next cycle.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N when the buffer was empty.
- Throughput is 1 instruction per cycle when out_ready is held high.
- While rst_n is low:
  - count = 0, pointers = 0.
  - out_valid = 0, in_ready = 0.
  - All out_* data outputs = 0.
- After reset deasserts, in_ready = 1.
- Reset asserted mid-operation clears the buffer immediately, asynchronously.
- out_* data are stable while out_valid && !out_ready. Entries are never reordered or duplicated.
- When count = DEPTH, in_ready = 0. A pop in that cycle frees a slot, and in_ready rises on the next cycle.

## Configuration
- DECODE_ILLEGAL_CHK_EN defined: out_illegal = 1 if any of the following holds:
  - out_fmt = X;
  - instr[1:0] != 2'b11;
  - R-format with func7 not in {0000000, 0100000, 0000001}.
  The flag is stored per entry.
- DECODE_ILLEGAL_CHK_EN undefined: out_illegal is tied to 0 and no flag storage is built.

## Structure
- Package decode_pkg holds:
  - opcode localparams;
  - fmt_e enum (R, I, S, B, U, J, X);
  - the decoded-entry struct: opcode, func3, func7, rs1, rs2, rd, fmt, imm, pc, illegal.
- One sub-module, imm_gen, is combinational: it takes instr and fmt and produces the XLEN immediate, and is parametrised by XLEN.
- Buffer pointers and count live in decode_stage.

## Test plan
- lw x2,1(x1), 0x0010A103, at XLEN=32 -> after 1 cycle: out_opcode=0000011, out_func3=010, out_rs1=1, out_rd=2, out_fmt=1, out_imm=1.
- beq x0,x0,-4, 0xFE000EE3 -> out_fmt=3, out_imm=0xFFFFFFFC. sw x1,-8(x2), 0xFE112C23 -> out_fmt=2, out_rs1=2, out_rs2=1, out_imm=0xFFFFFFF8. jal x1,8, 0x008000EF -> out_fmt=5, out_rd=1, out_imm=8.
- Backpressure with DEPTH=2:
  - Hold out_ready=0 and offer 3 words -> in_ready drops after 2 accepts.
  - Release out_ready -> 2 entries pop in order, with PCs 0x0 then 0x4.
  - The third word is accepted the cycle after the first pop.
- Flush with 2 buffered entries and in_valid=1 -> next cycle out_valid=0 and in_ready=1. The flushed words never appear on the output.
- 0x00000000 with DECODE_ILLEGAL_CHK_EN -> out_fmt=7, out_illegal=1, out_imm=0. The same word without the macro -> out_illegal=0.
- rst_n pulsed low while 1 entry is buffered -> out_valid=0 and all out_* = 0 immediately. After release: in_ready=1, and no stale entry appears.
